fpseq: RTL and testbench

Phase sequencer for the F-PM floating-point/long-arithmetic datapath. Accepts one AWP instruction start from the main control, walks the F-PM phase signals (f1, f2, f4…f10, f13) with per-phase strob_fp / strob2_fp pulses, and loops on alignment, iteration and normalisation phases using status returned by F-PM. It signals completion or fault back to the main control. It sits between the CPU control unit and the fpm block.

---
 rtl/fpseq.sv | 180 ++++++++++++++++++
 tb/tb_fpseq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpseq.sv
// fpseq: F-PM phase sequencer. Each phase takes 2 cycles (A: strob_fp, B: strob2_fp); an AS op completes 11 cycles after start.
// No backpressure: start is only taken in IDLE. FPSEQ_GUARD_EN caps F8/F10 loops at GUARD_MAX and reports err.
module fpseq #(
  parameter int GUARD_MAX = 40
) (
  input  logic       __clk,
  input  logic       _0_f,
  input  logic       start,
  input  logic [7:9] ir,
  input  logic       pufa,
  input  logic       nrf,
  input  logic       fic_zero,
  input  logic       g,
  input  logic       nz,
  input  logic       ws,
  input  logic       fi,
  output logic       f1,
  output logic       f2,
  output logic       f4,
  output logic       f5,
  output logic       f6,
  output logic       f7,
  output logic       f8,
  output logic       f9,
  output logic       f10,
  output logic       f13,
  output logic       strob_fp,
  output logic       strob2_fp,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F4, S_F5, S_F6, S_F7, S_F8, S_F9, S_F10, S_F13, S_DONE
  } state_t;

  typedef enum logic [1:0] {C_AS, C_AF, C_MD, C_NR} cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, cls_d;
  logic   sub_q, sub_d;
  logic   short_q, short_d;
  logic   rep_q, rep_d;
  logic   err_q, err_d;
  logic   cap;
  logic   in_phase;

`ifdef FPSEQ_GUARD_EN
  localparam logic [5:0] CAP = 6'(GUARD_MAX - 1);
  logic [5:0] cnt_q, cnt_d;
  logic       guard_q, guard_d;
  logic       looping;
`else
  logic unused_guard;
  assign unused_guard = (GUARD_MAX > 0);
`endif

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    sub_d   = sub_q;
    short_d = short_q;
    rep_d   = rep_q;
    err_d   = err_q;
`ifdef FPSEQ_GUARD_EN
    cnt_d   = cnt_q;
    guard_d = guard_q;
    looping = 1'b0;
    cap     = (cnt_q == CAP);
`else
    cap     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (nrf || pufa)) begin
          state_d = S_F1;
          sub_d   = 1'b0;
          rep_d   = 1'b0;
          err_d   = 1'b0;
          short_d = ~ir[7] & ir[8];
          if (nrf)        cls_d = C_NR;
          else if (ir[8]) cls_d = C_MD;
          else if (ir[7]) cls_d = C_AF;
          else            cls_d = C_AS;
`ifdef FPSEQ_GUARD_EN
          cnt_d   = '0;
          guard_d = 1'b0;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (!sub_q) begin
          sub_d = 1'b1;
        end else begin
          sub_d = 1'b0;
          // A fault seen on B preempts every other transition.
          if (fi) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            case (state_q)
              S_F1:  state_d = (cls_q == C_NR) ? S_F10 : S_F2;
              S_F2:  state_d = (cls_q == C_AS) ? S_F6 : ((cls_q == C_AF) ? S_F5 : S_F4);
              S_F4:  state_d = S_F8;
              S_F5:  state_d = g ? S_F9 : S_F8;
              S_F6:  state_d = (cls_q == C_AF) ? S_F10 : S_F7;
              S_F7: begin
                if (cls_q == C_MD && ws && !rep_q) rep_d = 1'b1;
                else if (cls_q == C_MD && !short_q) state_d = S_F10;
                else state_d = S_F13;
              end
              S_F8:  if (fic_zero || cap) state_d = (cls_q == C_AF) ? S_F6 : S_F7;
              S_F9:  state_d = S_F10;
              S_F10: if (!nz || cap) state_d = S_F13;
              S_F13: state_d = S_DONE;
              default: state_d = S_IDLE;
            endcase
`ifdef FPSEQ_GUARD_EN
            looping = (state_q == S_F8 && !fic_zero) || (state_q == S_F10 && nz);
            cnt_d   = (looping && !cap) ? cnt_q + 6'd1 : 6'd0;
            if (looping && cap) guard_d = 1'b1;
            if (state_q == S_F13 && guard_q) err_d = 1'b1;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge __clk) begin
    if (_0_f) begin
      state_q <= S_IDLE;
      cls_q   <= C_AS;
      sub_q   <= 1'b0;
      short_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      sub_q   <= sub_d;
      short_q <= short_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

`ifdef FPSEQ_GUARD_EN
  always_ff @(posedge __clk) begin
    if (_0_f) begin
      cnt_q   <= '0;
      guard_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
    end
  end
`endif

  assign f1  = (state_q == S_F1);
  assign f2  = (state_q == S_F2);
  assign f4  = (state_q == S_F4);
  assign f5  = (state_q == S_F5);
  assign f6  = (state_q == S_F6);
  assign f7  = (state_q == S_F7);
  assign f8  = (state_q == S_F8);
  assign f9  = (state_q == S_F9);
  assign f10 = (state_q == S_F10);
  assign f13 = (state_q == S_F13);

  assign in_phase  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign strob_fp  = in_phase & ~sub_q;
  assign strob2_fp = in_phase & sub_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done & err_q;

endmodule

// File: tb/tb_fpseq.sv
// Bench for fpseq: per-cycle expected phase/strobe/status vectors are queued per scenario and popped each cycle.
`timescale 1ns/1ps
module tb_fpseq;

  logic       __clk = 1'b0;
  logic       _0_f, start, pufa, nrf, fic_zero, g, nz, ws, fi;
  logic [7:9] ir;
  logic f1, f2, f4, f5, f6, f7, f8, f9, f10, f13;
  logic strob_fp, strob2_fp, busy, done, err;

  typedef struct packed {
    logic [9:0] f;
    logic       s1;
    logic       s2;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  localparam int P_F1 = 9, P_F2 = 8, P_F4 = 7, P_F5 = 6, P_F6 = 5;
  localparam int P_F7 = 4, P_F8 = 3, P_F9 = 2, P_F10 = 1, P_F13 = 0;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 __clk = ~__clk;

  fpseq #(.GUARD_MAX(40)) dut (
    .__clk(__clk), ._0_f(_0_f), .start(start), .ir(ir), .pufa(pufa), .nrf(nrf),
    .fic_zero(fic_zero), .g(g), .nz(nz), .ws(ws), .fi(fi),
    .f1(f1), .f2(f2), .f4(f4), .f5(f5), .f6(f6), .f7(f7), .f8(f8), .f9(f9),
    .f10(f10), .f13(f13), .strob_fp(strob_fp), .strob2_fp(strob2_fp),
    .busy(busy), .done(done), .err(err)
  );

  function automatic obs_t sample();
    obs_t o;
    o.f    = {f1, f2, f4, f5, f6, f7, f8, f9, f10, f13};
    o.s1   = strob_fp;
    o.s2   = strob2_fp;
    o.busy = busy;
    o.done = done;
    o.err  = err;
    return o;
  endfunction

  task automatic push_half(input int p, input bit b);
    obs_t o;
    o      = '0;
    o.f    = 10'(1) << p;
    o.s1   = ~b;
    o.s2   = b;
    o.busy = 1'b1;
    exp_q.push_back(o);
  endtask

  task automatic push_phase(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      push_half(p, 1'b0);
      push_half(p, 1'b1);
    end
  endtask

  task automatic push_done(input bit e);
    obs_t o;
    o      = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    o.err  = e;
    exp_q.push_back(o);
  endtask

  task automatic push_idle(input int n);
    obs_t o;
    o = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(o);
  endtask

  task automatic idle_inputs();
    start = 1'b0; ir = 3'd0; pufa = 1'b0; nrf = 1'b0;
    fic_zero = 1'b0; g = 1'b0; nz = 1'b0; ws = 1'b0; fi = 1'b0;
  endtask

  task automatic kick(input logic [2:0] op, input logic p, input logic n);
    @(negedge __clk);
    ir = op; pufa = p; nrf = n; start = 1'b1;
  endtask

  task automatic test_reset();
    obs_t ob;
    idle_inputs();
    _0_f = 1'b1;
    repeat (2) @(posedge __clk);
    @(negedge __clk);
    ob = sample();
    tests++;
    if (ob !== obs_t'(0)) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=%b", ob, obs_t'(0));
    end
    _0_f = 1'b0;
  endtask

  task automatic test_ignore();
    obs_t ev, ob;
    int cyc = 0;
    idle_inputs();
    push_idle(3);
    kick(3'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL ignore_start cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      cyc++;
    end
  endtask

  task automatic test_as();
    obs_t ev, ob;
    int cyc = 0;
    idle_inputs();
    push_phase(P_F1, 1); push_phase(P_F2, 1); push_phase(P_F6, 1);
    push_phase(P_F7, 1); push_phase(P_F13, 1); push_done(1'b0); push_idle(2);
    kick(3'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL as_trace cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      cyc++;
    end
  endtask

  task automatic test_af_loop();
    obs_t ev, ob;
    int cyc = 0;
    int f8b = 0;
    idle_inputs();
    push_phase(P_F1, 1); push_phase(P_F2, 1); push_phase(P_F5, 1); push_phase(P_F8, 3);
    push_phase(P_F6, 1); push_phase(P_F10, 1); push_phase(P_F13, 1); push_done(1'b0); push_idle(1);
    kick(3'd4, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL af_f8_loop cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      fic_zero = 1'b0;
      if (ev.f[P_F8] && ev.s2) begin
        fic_zero = (f8b == 2);
        f8b++;
      end
      cyc++;
    end
  endtask

  task automatic test_af_far();
    obs_t ev, ob;
    int cyc = 0;
    int f10b = 0;
    idle_inputs();
    g = 1'b1;
    push_phase(P_F1, 1); push_phase(P_F2, 1); push_phase(P_F5, 1); push_phase(P_F9, 1);
    push_phase(P_F10, 3); push_phase(P_F13, 1); push_done(1'b0); push_idle(1);
    kick(3'd5, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL af_far_f10 cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      nz = 1'b0;
      if (ev.f[P_F10] && ev.s2) begin
        nz = (f10b < 2);
        f10b++;
      end
      cyc++;
    end
  endtask

  task automatic test_md_ws();
    obs_t ev, ob;
    int cyc = 0;
    idle_inputs();
    ws = 1'b1; fic_zero = 1'b1;
    push_phase(P_F1, 1); push_phase(P_F2, 1); push_phase(P_F4, 1); push_phase(P_F8, 1);
    push_phase(P_F7, 2); push_phase(P_F10, 1); push_phase(P_F13, 1); push_done(1'b0); push_idle(1);
    kick(3'd6, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL mf_ws_repeat cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      cyc++;
    end
  endtask

  task automatic test_dw_skip();
    obs_t ev, ob;
    int cyc = 0;
    idle_inputs();
    ws = 1'b1; fic_zero = 1'b1; nz = 1'b1;
    push_phase(P_F1, 1); push_phase(P_F2, 1); push_phase(P_F4, 1); push_phase(P_F8, 1);
    push_phase(P_F7, 2); push_phase(P_F13, 1); push_done(1'b0); push_idle(1);
    kick(3'd3, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL dw_skip_f10 cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      cyc++;
    end
  endtask

  task automatic test_fault();
    obs_t ev, ob;
    int cyc = 0;
    idle_inputs();
    push_phase(P_F1, 1); push_phase(P_F2, 1); push_done(1'b1); push_idle(2);
    kick(3'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL fault_trace cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      fi = (ev.f[P_F1] && ev.s1) || (ev.f[P_F2] && ev.s2);
      if (ev.done) start = 1'b1;
      cyc++;
    end
  endtask

  task automatic test_reset_mid_f8();
    obs_t ev, ob;
    int cyc = 0;
    idle_inputs();
    push_phase(P_F1, 1); push_phase(P_F2, 1); push_phase(P_F5, 1); push_phase(P_F8, 1);
    push_half(P_F8, 1'b0); push_idle(4);
    kick(3'd4, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL reset_mid_f8 cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      _0_f = (cyc == 8);
      cyc++;
    end
  endtask

  task automatic test_nr_guard();
    obs_t ev, ob;
    int cyc = 0;
    idle_inputs();
    nz = 1'b1;
    push_phase(P_F1, 1);
`ifdef FPSEQ_GUARD_EN
    push_phase(P_F10, 40); push_phase(P_F13, 1); push_done(1'b1); push_idle(1);
`else
    push_phase(P_F10, 50);
`endif
    kick(3'd0, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge __clk);
      start = 1'b0;
      ev = exp_q.pop_front();
      ob = sample();
      tests++;
      if (ob !== ev) begin
        fails++;
        $display("FAIL nr_f10_guard cyc=%0d got=%b want=%b", cyc, ob, ev);
      end
      cyc++;
    end
    _0_f = 1'b1;
    @(negedge __clk);
    _0_f = 1'b0;
    ob = sample();
    tests++;
    if (ob !== obs_t'(0)) begin
      fails++;
      $display("FAIL nr_final_idle got=%b want=%b", ob, obs_t'(0));
    end
  endtask

  initial begin
    _0_f = 1'b1;
    idle_inputs();
    test_reset();
    test_ignore();
    test_as();
    test_af_loop();
    test_af_far();
    test_md_ws();
    test_dw_skip();
    test_fault();
    test_reset_mid_f8();
    test_nr_guard();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
